mealy_bit_serializer: RTL and testbench
=======================================

Name: mealy_bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage: takes parallel words over a valid/ready handshake and emits them one bit per clock on a serial output that drives the detector's x input.
- Double-buffered: one shift register plus a 1-deep holding register, so consecutive words stream with no gap bits.
- Provides an enable stall, a busy indication and a sticky underrun flag for stream gaps.

Parameters:
- WIDTH, 8, word width in bits, minimum 2.
- MSB_FIRST, 1, 1 = serialize bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept din this cycle.
- enable  input  1  1 = shift one bit this cycle, 0 = stall.
- x_out  output  1  serial bit to the detector.
- x_valid  output  1  x_out carries a real data bit this cycle.
- busy  output  1  shift register or holding register occupied.
- underrun  output  1  sticky flag: a word finished and no next word was ready.
- clr_underrun  input  1  synchronous clear of underrun.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. Reset clears sh, sh_full, cnt, hold, hold_full and underrun.
- Outputs after reset: din_ready=1, x_valid=0, x_out=0, busy=0, underrun=0.
- Internal state:
  - sh[WIDTH-1:0], the shift register, and sh_full.
  - cnt, the bit index, range 0..WIDTH-1, width $clog2(WIDTH).
  - hold[WIDTH-1:0] and hold_full.
- Combinational outputs:
  - din_ready = !hold_full.
  - accept = din_valid && din_ready.
  - consume = sh_full && enable.
  - x_valid = consume.
  - x_out = consume ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : 0.
  - busy = sh_full || hold_full.
- last = consume && (cnt == WIDTH-1). free = !sh_full || last.
- Per-edge update, exactly one case applies:
  - free && hold_full: sh<=hold, cnt<=0, sh_full<=1, hold_full<=0. accept is impossible in this case.
  - free && !hold_full && accept: sh<=din (bypass), cnt<=0, sh_full<=1.
  - free && !hold_full && !accept: sh_full<=0 and cnt<=0.
  - !free && accept: hold<=din, hold_full<=1.
  - Otherwise, if consume && !last: sh shifts by one toward the output end, zero fill. Left shift if MSB_FIRST, right shift otherwise. cnt<=cnt+1.
- Latency: a word accepted at edge N into an empty block gives its first bit at x_valid in the cycle after edge N.
- With enable held high, a word occupies exactly WIDTH consecutive x_valid cycles.
- Gapless streaming: if the next word is in hold, or is accepted, no later than the cycle of the last bit, the next word's first bit follows immediately.
- enable=0: no shift, cnt holds, x_valid=0, x_out=0. Acceptance into the empty sh or hold still proceeds.
- Underrun:
  - Set at the edge where last=1, hold_full=0 and accept=0.
  - clr_underrun clears it; set wins when both occur in the same cycle.
- Reset mid-word: the partial word and the held word are discarded, and outputs return to reset values immediately (asynchronous).
- din is sampled only on accept. din changing while din_ready=0 has no effect.

Test Plan:
- WIDTH=8, MSB_FIRST=1, enable=1, single din=0xA0 accepted at edge 0:
  - x_valid is 1 for cycles 1..8 and x_out is 1,0,1,0,0,0,0,0.
  - underrun rises after the edge of cycle 8.
  - busy falls in cycle 9.
- Back-to-back 0xAA then 0x55, din_valid held high:
  - First word bypasses to sh, second goes to hold, and din_ready=0 until the edge of cycle 8.
  - x_out gives 16 gapless bits 10101010 01010101.
  - underrun stays 0 until after the second word.
- Stall: 0xF0 with enable=0 in cycles 3-5:
  - x_valid=0 and x_out=0 in those cycles.
  - The remaining bits resume unchanged and all 8 bits of 0xF0 still appear in order.
- MSB_FIRST=0, din=0x01: x_out is 1,0,0,0,0,0,0,0.
- Underrun flag behaviour:
  - With underrun=1, asserting clr_underrun in an idle cycle gives underrun=0 next cycle.
  - With clr_underrun and a new set condition in the same cycle, underrun stays 1.
- Reset mid-stream:
  - Assert rst_n=0 in bit 4 of 0xAA while 0x55 is held: x_valid, busy and underrun go to 0 immediately and din_ready=1.
  - After release, a new 0x0F serializes cleanly.

Source files
------------

// File: rtl/mealy_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input,
// one shift register plus a one-deep holding register for gapless streaming.
module mealy_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             enable,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             underrun,
    input  logic             clr_underrun
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sh_full_q, sh_full_d;
    logic             hold_full_q, hold_full_d;
    logic             underrun_q, underrun_d;
    logic             accept_s, consume_s, last_s, free_s;

    // Move the shift register one bit toward its output end, zero fill.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Handshake and word-boundary terms shared by next-state and output logic.
    always_comb begin
        consume_s = sh_full_q & enable;
        accept_s  = din_valid & ~hold_full_q;
        last_s    = consume_s & (cnt_q == CNT_LAST);
        free_s    = ~sh_full_q | last_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= {WIDTH{1'b0}};
            hold_q      <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            sh_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            sh_full_q   <= sh_full_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next state: refill the shift register when it frees up, otherwise park
    // an accepted word in hold while the current word keeps shifting.
    always_comb begin
        sh_d        = sh_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        sh_full_d   = sh_full_q;
        hold_full_d = hold_full_q;
        if (free_s) begin
            cnt_d = {CW{1'b0}};
            if (hold_full_q) begin
                sh_d        = hold_q;
                sh_full_d   = 1'b1;
                hold_full_d = 1'b0;
            end else if (accept_s) begin
                sh_d      = din;
                sh_full_d = 1'b1;
            end else begin
                sh_full_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end else begin
                hold_full_d = hold_full_q;
            end
            if (consume_s) begin
                sh_d  = shift_once(sh_q);
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
        // A fresh underrun event takes priority over a clear in the same cycle.
        if (last_s && !hold_full_q && !accept_s) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Outputs.
    always_comb begin
        din_ready = ~hold_full_q;
        x_valid   = consume_s;
        if (consume_s) begin
            x_out = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
        end else begin
            x_out = 1'b0;
        end
        busy     = sh_full_q | hold_full_q;
        underrun = underrun_q;
    end

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Self-checking bench for mealy_bit_serializer: vector table, directed corner
// sequences, and a random run against a queue-based reference model.
module tb_mealy_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid, enable, clr_underrun;
    logic       din_ready, x_out, x_valid, busy, underrun;
    logic [7:0] l_din;
    logic       l_valid, l_enable, l_clr;
    logic       l_ready, l_xo, l_xv, l_busy, l_under;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mealy_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .enable(enable), .x_out(x_out),
        .x_valid(x_valid), .busy(busy), .underrun(underrun),
        .clr_underrun(clr_underrun)
    );

    mealy_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_valid),
        .din_ready(l_ready), .enable(l_enable), .x_out(l_xo),
        .x_valid(l_xv), .busy(l_busy), .underrun(l_under),
        .clr_underrun(l_clr)
    );

    typedef struct {
        logic [7:0] din;
        logic       dv, en, clr;
        logic       e_rdy, e_xv, e_xo, e_busy, e_und;
    } vec_t;

    vec_t tbl[12];

    // Reference model: remaining bits of the word being sent, plus the held word.
    bit         mq[$];
    bit         m_hold_v;
    logic [7:0] m_hold;
    bit         m_und;

    function automatic vec_t mk(input logic [7:0] d, input logic dv, en, clr,
                                input logic rdy, xv, xo, bs, und);
        vec_t v;
        v.din = d; v.dv = dv; v.en = en; v.clr = clr;
        v.e_rdy = rdy; v.e_xv = xv; v.e_xo = xo; v.e_busy = bs; v.e_und = und;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, en, clr);
        din = d; din_valid = dv; enable = en; clr_underrun = clr;
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        l_din = 8'h00; l_valid = 1'b0; l_enable = 1'b1; l_clr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mq.delete();
        m_hold_v = 1'b0;
        m_hold   = 8'h00;
        m_und    = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) mq.push_back(w[i]);
    endtask

    task automatic model_step(input logic [7:0] d, input logic dv, en, clr);
        bit acc, cons, fin, und_set;
        acc  = dv && !m_hold_v;
        cons = (mq.size() != 0) && en;
        fin  = 1'b0;
        if (cons) begin
            mq.delete(0);
            fin = (mq.size() == 0);
        end
        und_set = fin && !m_hold_v && !acc;
        if (mq.size() == 0) begin
            if (m_hold_v) begin
                push_word(m_hold);
                m_hold_v = 1'b0;
            end else if (acc) begin
                push_word(d);
            end
        end else if (acc) begin
            m_hold   = d;
            m_hold_v = 1'b1;
        end
        m_und = und_set ? 1'b1 : (clr ? 1'b0 : m_und);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] pat16;
        logic [7:0]  got;
        int          n;
        bit          e_xv, e_xo;

        // Single word 0xA0, then clear of underrun in an idle cycle.
        pat = 8'hA0;
        tbl[0] = mk(8'hA0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            tbl[i] = mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, pat[8-i], 1'b1, 1'b0);
        tbl[9]  = mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        cyc = 0;
        chk("reset_ready", din_ready, 1'b1);
        chk("reset_xv", x_valid, 1'b0);
        chk("reset_xo", x_out, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_under", underrun, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].din, tbl[i].dv, tbl[i].en, tbl[i].clr);
            chk("tbl_ready", din_ready, tbl[i].e_rdy);
            chk("tbl_xv", x_valid, tbl[i].e_xv);
            chk("tbl_xo", x_out, tbl[i].e_xo);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_under", underrun, tbl[i].e_und);
            tick();
        end

        // Back-to-back 0xAA then 0x55: 16 gapless bits.
        cyc = 0;
        pat16 = 16'hAA55;
        drive(8'hAA, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 1; c <= 17; c++) begin
            drive(8'h55, (c == 1), 1'b1, 1'b0);
            if (c <= 9) chk("b2b_ready", din_ready, (c == 1 || c == 9));
            chk("b2b_xv", x_valid, (c <= 16));
            chk("b2b_xo", x_out, (c <= 16) ? pat16[16-c] : 1'b0);
            chk("b2b_under", underrun, (c == 17));
            tick();
        end

        // Stall 0xF0 with enable low in cycles 3..5.
        cyc = 0;
        got = 8'h00;
        n = 0;
        drive(8'hF0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 1; c <= 11; c++) begin
            drive(8'h00, 1'b0, !(c >= 3 && c <= 5), 1'b0);
            if (c >= 3 && c <= 5) begin
                chk("stall_xv", x_valid, 1'b0);
                chk("stall_xo", x_out, 1'b0);
            end else begin
                chk("stall_run_xv", x_valid, 1'b1);
            end
            if (x_valid) begin
                got = {got[6:0], x_out};
                n++;
            end
            tick();
        end
        chk("stall_bits", got, 8'hF0);
        chk("stall_count", n, 8);

        // Underrun: clear while idle, then clear colliding with a new set.
        cyc = 0;
        pat = 8'h81;
        drive(8'h81, 1'b1, 1'b1, 1'b1);
        chk("und_before_clr", underrun, 1'b1);
        tick();
        for (int c = 1; c <= 9; c++) begin
            drive(8'h00, 1'b0, 1'b1, (c == 8));
            if (c <= 8) chk("und_word_xo", x_out, pat[8-c]);
            chk("und_flag", underrun, (c == 9));
            tick();
        end

        // Reset mid-word with a word held.
        cyc = 0;
        drive(8'hAA, 1'b1, 1'b1, 1'b0);
        tick();
        drive(8'h55, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 2; c <= 4; c++) begin
            drive(8'h00, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        chk("mid_busy", busy, 1'b1);
        chk("mid_ready", din_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_xv", x_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_under", underrun, 1'b0);
        chk("rst_ready", din_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc = 0;
        pat = 8'h0F;
        drive(8'h0F, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 1; c <= 9; c++) begin
            drive(8'h00, 1'b0, 1'b1, 1'b0);
            chk("post_rst_xv", x_valid, (c <= 8));
            chk("post_rst_xo", x_out, (c <= 8) ? pat[8-c] : 1'b0);
            chk("post_rst_under", underrun, (c == 9));
            tick();
        end

        // LSB-first instance: 0x01 gives a single leading one.
        cyc = 0;
        l_din = 8'h01; l_valid = 1'b1;
        #2;
        tick();
        l_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #2;
            chk("lsb_xv", l_xv, (c <= 8));
            chk("lsb_xo", l_xo, (c == 1));
            chk("lsb_under", l_under, (c == 9));
            tick();
        end

        // Random traffic against the reference model.
        do_reset();
        cyc = 0;
        for (int k = 0; k < 600; k++) begin
            logic [7:0] rd;
            logic       rv, re, rc;
            rd = 8'($urandom);
            rv = ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 80);
            rc = ($urandom_range(0, 99) < 8);
            drive(rd, rv, re, rc);
            e_xv = (mq.size() != 0) && re;
            e_xo = e_xv ? mq[0] : 1'b0;
            chk("rnd_ready", din_ready, !m_hold_v);
            chk("rnd_xv", x_valid, e_xv);
            chk("rnd_xo", x_out, e_xo);
            chk("rnd_busy", busy, (mq.size() != 0) || m_hold_v);
            chk("rnd_under", underrun, m_und);
            model_step(rd, rv, re, rc);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
